// File: rtl/stack_engine_pkg.sv
// Shared register-select codes and sequencer state encoding for the stack engine.
package stack_engine_pkg;

    typedef logic [3:0] reg_select;

    localparam reg_select REG_AF = 4'd0;
    localparam reg_select REG_BC = 4'd1;
    localparam reg_select REG_DE = 4'd2;
    localparam reg_select REG_HL = 4'd3;
    localparam reg_select REG_IX = 4'd4;
    localparam reg_select REG_IY = 4'd5;
    localparam reg_select REG_SP = 4'd6;
    localparam reg_select REG_A  = 4'd7;
    localparam reg_select REG_F  = 4'd8;
    localparam reg_select REG_PC = 4'd9;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_HI,
        S_WR_LO,
        S_RD_LO,
        S_RD_HI,
        S_WB_PAIR,
        S_UPD_SP
    } se_state_t;

    // Only the six pairs that PUSH/POP can name are legal stack operands.
    function automatic logic is_stack_pair(input reg_select sel);
        return sel inside {REG_AF, REG_BC, REG_DE, REG_HL, REG_IX, REG_IY};
    endfunction

endpackage

// File: rtl/stack_engine.sv
// PUSH rr / POP rr micro-sequencer between register file and byte-wide memory port.
// Optional illegal-pair check and err port: define STACK_ENGINE_CHECK_EN.
module stack_engine
    import stack_engine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  reg_select   pair,
    output logic        busy,
    output logic        done,
    output reg_select   src1,
    output reg_select   src2,
    input  logic [15:0] rd1,
    input  logic [15:0] rd2,
    output logic        write_en,
    output reg_select   dest,
    output logic [15:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
`ifdef STACK_ENGINE_CHECK_EN
    ,
    output logic        err
`endif
);

    se_state_t   r_state;
    logic        r_op;
    reg_select   r_pair;
    logic [15:0] r_sp;
    logic [15:0] r_val;
    logic [7:0]  r_lo;

    logic        r_busy;
    logic        r_done;
    reg_select   r_src1;
    reg_select   r_src2;
    logic        r_write_en;
    reg_select   r_dest;
    logic [15:0] r_wdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;

    logic        w_illegal;

`ifdef STACK_ENGINE_CHECK_EN
    logic        r_err;
    assign w_illegal = !is_stack_pair(pair);
    assign err       = r_err;
`else
    assign w_illegal = 1'b0;
`endif

    // NOTE: every output is a flop set on the transition into its state, so each
    // branch below assigns the values the *next* state presents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_PUSH;
            r_pair      <= REG_AF;
            r_sp        <= '0;
            r_val       <= '0;
            r_lo        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_src1      <= REG_AF;
            r_src2      <= REG_AF;
            r_write_en  <= 1'b0;
            r_dest      <= REG_AF;
            r_wdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef STACK_ENGINE_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_write_en <= 1'b0;
`ifdef STACK_ENGINE_CHECK_EN
            r_err      <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (start && w_illegal) begin
                        r_done <= 1'b1;
`ifdef STACK_ENGINE_CHECK_EN
                        r_err  <= 1'b1;
`endif
                    end else if (start) begin
                        r_op    <= op;
                        r_pair  <= pair;
                        r_src1  <= REG_SP;
                        r_src2  <= pair;
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_sp      <= rd1;
                    r_val     <= rd2;
                    r_mem_req <= 1'b1;
                    if (r_op == OP_PUSH) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= rd1 - 16'd1;
                        r_mem_wdata <= rd2[15:8];
                        r_state     <= S_WR_HI;
                    end else begin
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= rd1;
                        r_state     <= S_RD_LO;
                    end
                end
                S_WR_HI: begin
                    if (mem_ack) begin
                        r_mem_addr  <= r_sp - 16'd2;
                        r_mem_wdata <= r_val[7:0];
                        r_state     <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_write_en  <= 1'b1;
                        r_dest      <= REG_SP;
                        r_wdata     <= r_sp - 16'd2;
                        r_done      <= 1'b1;
                        r_state     <= S_UPD_SP;
                    end
                end
                S_RD_LO: begin
                    if (mem_ack) begin
                        r_lo       <= mem_rdata;
                        r_mem_addr <= r_sp + 16'd1;
                        r_state    <= S_RD_HI;
                    end
                end
                S_RD_HI: begin
                    // High byte goes straight into the pair write; no separate hold register needed.
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                        r_write_en <= 1'b1;
                        r_dest     <= r_pair;
                        r_wdata    <= {mem_rdata, r_lo};
                        r_state    <= S_WB_PAIR;
                    end
                end
                S_WB_PAIR: begin
                    r_write_en <= 1'b1;
                    r_dest     <= REG_SP;
                    r_wdata    <= r_sp + 16'd2;
                    r_done     <= 1'b1;
                    r_state    <= S_UPD_SP;
                end
                S_UPD_SP: begin
                    r_busy  <= 1'b0;
                    r_src1  <= REG_AF;
                    r_src2  <= REG_AF;
                    r_dest  <= REG_AF;
                    r_wdata <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign src1      = r_src1;
    assign src2      = r_src2;
    assign write_en  = r_write_en;
    assign dest      = r_dest;
    assign wdata     = r_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed cases plus randomized PUSH/POP against an arithmetic stack model.
module tb_stack_engine;
    import stack_engine_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    reg_select   pair;
    logic        busy, done;
    reg_select   src1, src2, dest;
    logic [15:0] rd1, rd2, wdata, mem_addr;
    logic        write_en, mem_req, mem_we, mem_ack;
    logic [7:0]  mem_wdata, mem_rdata;
`ifdef STACK_ENGINE_CHECK_EN
    logic        err;
`endif

    logic [15:0] regs [0:15];
    logic [7:0]  mem  [0:65535];

    int n_pass = 0, n_total = 0;
    int n_done = 0, n_rf_wr = 0, n_mem_wr = 0;
    int ack_delay = 0, wait_cnt = 0, unstable = 0;
    bit in_txn = 0, spur_ack = 0;
    logic        r_ack;
    logic [15:0] t_addr;
    logic        t_we;
    logic [7:0]  t_wd;

    assign rd1     = regs[src1];
    assign rd2     = regs[src2];
    assign mem_ack = r_ack | spur_ack;

    always #5 clk = ~clk;

    stack_engine dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .pair(pair),
        .busy(busy), .done(done), .src1(src1), .src2(src2),
        .rd1(rd1), .rd2(rd2), .write_en(write_en), .dest(dest), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef STACK_ENGINE_CHECK_EN
        , .err(err)
`endif
    );

    // Memory responder: acks after ack_delay wait cycles and flags any request change while waiting.
    initial begin
        r_ack     = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset || !mem_req) begin
                r_ack  = 1'b0;
                in_txn = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                    t_addr   = mem_addr;
                    t_we     = mem_we;
                    t_wd     = mem_wdata;
                end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wd) begin
                    unstable++;
                end
                if (wait_cnt >= ack_delay) begin
                    r_ack     = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    r_ack = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Edge-side effects: memory writes, register-file writes, done pulses.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && mem_req && mem_ack) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    n_mem_wr++;
                end
                in_txn = 1'b0;
            end
            if (!reset && write_en) begin
                regs[dest] = wdata;
                n_rf_wr++;
            end
            if (!reset && done) n_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issues one operation and returns the cycle (1 = first cycle after the start edge) in which done appeared.
    task automatic run_op(input logic o, input reg_select p, input int dly, output int cyc);
        ack_delay = dly;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        pair  = p;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        @(negedge clk);
    endtask

    initial begin
        int          cyc, d0, w0, m0, dly;
        logic        o;
        reg_select   p;
        logic [15:0] sp, val, a_hi, a_lo, exp_sp, exp_val;
        logic [7:0]  exp_hi, exp_lo;
        bit          found;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        pair  = REG_AF;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);

        repeat (2) @(negedge clk);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_done",     32'(done),     32'd0);
        check("reset_mem_req",  32'(mem_req),  32'd0);
        check("reset_write_en", 32'(write_en), 32'd0);
        check("reset_src1",     32'(src1),     32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;

        // PUSH BC=0x1234 from SP=0x0000, zero wait
        regs[REG_SP] = 16'h0000;
        regs[REG_BC] = 16'h1234;
        d0 = n_done;
        run_op(OP_PUSH, REG_BC, 0, cyc);
        check("push_latency", 32'(cyc),           32'd4);
        check("push_hi_byte", 32'(mem[16'hFFFF]), 32'h12);
        check("push_lo_byte", 32'(mem[16'hFFFE]), 32'h34);
        check("push_sp",      32'(regs[REG_SP]),  32'hFFFE);
        check("push_done_n",  32'(n_done - d0),   32'd1);
        check("push_idle",    32'(busy),          32'd0);

        // POP HL from SP=0xFFFE, wraps to 0x0000
        regs[REG_HL] = 16'h0000;
        run_op(OP_POP, REG_HL, 0, cyc);
        check("pop_latency", 32'(cyc),          32'd5);
        check("pop_hl",      32'(regs[REG_HL]), 32'h1234);
        check("pop_sp_wrap", 32'(regs[REG_SP]), 32'h0000);

        // PUSH DE with three wait cycles per byte
        regs[REG_SP] = 16'h4000;
        regs[REG_DE] = 16'hABCD;
        unstable = 0;
        run_op(OP_PUSH, REG_DE, 3, cyc);
        check("wait_latency", 32'(cyc),           32'd10);
        check("wait_stable",  32'(unstable),      32'd0);
        check("wait_hi_byte", 32'(mem[16'h3FFF]), 32'hAB);
        check("wait_lo_byte", 32'(mem[16'h3FFE]), 32'hCD);
        check("wait_sp",      32'(regs[REG_SP]),  32'h3FFE);

        // Second start while busy must be ignored
        regs[REG_SP] = 16'h2000;
        regs[REG_IX] = 16'h9876;
        ack_delay = 0;
        d0 = n_done; w0 = n_rf_wr; m0 = n_mem_wr;
        @(negedge clk);
        start = 1'b1; op = OP_PUSH; pair = REG_IX;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = OP_POP; pair = REG_HL;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_start_done_n", 32'(n_done - d0),    32'd1);
        check("busy_start_rf_wr",  32'(n_rf_wr - w0),   32'd1);
        check("busy_start_mem_wr", 32'(n_mem_wr - m0),  32'd2);
        check("busy_start_sp",     32'(regs[REG_SP]),   32'h1FFE);
        check("busy_start_idle",   32'(busy),           32'd0);

        // mem_ack while idle is ignored
        d0 = n_done; w0 = n_rf_wr;
        spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        check("idle_ack_busy",  32'(busy),          32'd0);
        check("idle_ack_rf_wr", 32'(n_rf_wr - w0),  32'd0);
        check("idle_ack_done",  32'(n_done - d0),   32'd0);

        // Reset during WR_LO of a PUSH from SP=0x8000
        regs[REG_SP] = 16'h8000;
        regs[REG_BC] = 16'h5AA5;
        ack_delay = 2;
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; op = OP_PUSH; pair = REG_BC;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h7FFE) found = 1'b1;
        end
        check("rst_reach_wr_lo", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_mem_req",  32'(mem_req),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sp_kept", 32'(regs[REG_SP]), 32'h8000);
        check("rst_no_done", 32'(n_done - d0),  32'd0);
        check("rst_idle",    32'(busy),         32'd0);

        // Randomized operations against an arithmetic stack model
        for (int i = 0; i < 12; i++) begin
            o   = 1'($urandom_range(0, 1));
            p   = reg_select'($urandom_range(0, 5));
            val = 16'($urandom);
            dly = int'($urandom_range(0, 2));
            if (i == 0)      sp = 16'h0001;
            else if (i == 1) sp = 16'hFFFF;
            else             sp = 16'($urandom);
            regs[REG_SP] = sp;
            d0 = n_done;
            if (o == OP_PUSH) begin
                regs[p] = val;
                a_hi    = sp - 16'd1;
                a_lo    = sp - 16'd2;
                exp_sp  = sp - 16'd2;
                run_op(o, p, dly, cyc);
                check("rnd_push_latency", 32'(cyc),       32'(4 + 2 * dly));
                check("rnd_push_hi",      32'(mem[a_hi]), 32'(val[15:8]));
                check("rnd_push_lo",      32'(mem[a_lo]), 32'(val[7:0]));
            end else begin
                exp_lo  = mem[sp];
                exp_hi  = mem[16'(sp + 16'd1)];
                exp_val = {exp_hi, exp_lo};
                exp_sp  = sp + 16'd2;
                regs[p] = ~exp_val;
                run_op(o, p, dly, cyc);
                check("rnd_pop_latency", 32'(cyc),     32'(5 + 2 * dly));
                check("rnd_pop_pair",    32'(regs[p]), 32'(exp_val));
            end
            check("rnd_sp",     32'(regs[REG_SP]), 32'(exp_sp));
            check("rnd_done_n", 32'(n_done - d0),  32'd1);
        end

`ifdef STACK_ENGINE_CHECK_EN
        // Illegal pair: err and done pulse once, no transactions
        @(negedge clk);
        start = 1'b1; op = OP_PUSH; pair = REG_A;
        @(posedge clk);
        #1 start = 1'b0;
        check("illegal_err",      32'(err),      32'd1);
        check("illegal_done",     32'(done),     32'd1);
        check("illegal_mem_req",  32'(mem_req),  32'd0);
        check("illegal_write_en", 32'(write_en), 32'd0);
        @(posedge clk);
        #1;
        check("illegal_err_pulse",  32'(err),     32'd0);
        check("illegal_done_pulse", 32'(done),    32'd0);
        check("illegal_no_req",     32'(mem_req), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
